// File: rtl/match_game_pkg.sv
// Shared types and width helpers for the memory-match game controller.
package match_game_pkg;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_SHUFFLE  = 4'd1,
    ST_WRITE    = 4'd2,
    ST_S1C      = 4'd3,
    ST_F1C      = 4'd4,
    ST_S2C      = 4'd5,
    ST_SHOW     = 4'd6,
    ST_RESOLVE1 = 4'd7,
    ST_RESOLVE2 = 4'd8,
    ST_WIN      = 4'd9
  } state_t;

  // Card status codes, upper two bits of every board-memory word
  localparam logic [1:0] FACE_UP   = 2'b00;
  localparam logic [1:0] FACE_DOWN = 2'b01;
  localparam logic [1:0] REMOVED   = 2'b10;

  function automatic int loc_width(input int num_pairs);
    return $clog2(2 * num_pairs);
  endfunction

  function automatic int val_width(input int num_pairs);
    return $clog2(num_pairs + 1);
  endfunction

  function automatic int pl_width(input int num_players);
    return (num_players > 2) ? $clog2(num_players) : 1;
  endfunction

  function automatic int timer_width(input int cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/match_game_reveal_timer.sv
// Down-counter that holds the revealed pair on the board for load_value cycles.
module reveal_timer #(
  parameter int W = 25
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] load_value,
  output logic         done
);

  logic [W-1:0] cnt;

  // Load on start so the first SHOW cycle already counts; stop at zero.
  always_ff @(posedge clk) begin
    if (reset)            cnt <= '0;
    else if (start)       cnt <= load_value - W'(1);
    else if (cnt != '0)   cnt <= cnt - W'(1);
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/match_game_ctrl.sv
// Memory-match game controller: shuffles the board, runs turns, keeps score.
module match_game_ctrl
  import match_game_pkg::*;
#(
  parameter int NUM_PAIRS   = 8,
  parameter int NUM_PLAYERS = 2,
  parameter int SHOW_CYCLES = 2**24,
  localparam int LOC_W = loc_width(NUM_PAIRS),
  localparam int VAL_W = val_width(NUM_PAIRS),
  localparam int PL_W  = pl_width(NUM_PLAYERS)
) (
  input  logic                         Clk,
  input  logic                         Reset,
  input  logic                         Start,
  input  logic [LOC_W-1:0]             RandIn,
  input  logic                         RandValid,
  input  logic                         Select,
  input  logic [LOC_W-1:0]             CardSelectLoc,
  input  logic [VAL_W-1:0]             CardSelectData,
  input  logic                         Ack,
  output logic                         WriteEnable,
  output logic [LOC_W-1:0]             dataLoc,
  output logic [2+VAL_W-1:0]           dataOut,
  output logic [VAL_W-1:0]             numMatches,
  output logic [PL_W-1:0]              curPlayer,
  output logic [NUM_PLAYERS*VAL_W-1:0] scores,
  output logic [PL_W-1:0]              winner,
  output logic [3:0]                   state
);

  localparam int                 TWO_N    = 2 * NUM_PAIRS;
  localparam int                 TMR_W    = timer_width(SHOW_CYCLES);
  localparam logic [LOC_W:0]     TWO_N_X  = (LOC_W+1)'(TWO_N);
  localparam logic [LOC_W-1:0]   LAST_LOC = LOC_W'(TWO_N - 1);

  state_t state_q, state_d;

  logic [LOC_W-1:0]               perm [2**LOC_W];
  logic [2**LOC_W-1:0]            used, removed;
  logic [LOC_W-1:0]               k, wr_idx, wr_nxt;
  logic [VAL_W-1:0]               wr_val;
  logic [LOC_W-1:0]               card1_loc, card2_loc;
  logic [VAL_W-1:0]               card1_val, card2_val;
  logic [NUM_PLAYERS-1:0][VAL_W-1:0] score_r;
  logic                           sel_prev, sel_rise, accept, pick, tmr_start, show_done, is_match;
  logic [PL_W-1:0]                best;
  logic [VAL_W-1:0]               best_sc;

  assign sel_rise = Select & ~sel_prev;
  assign is_match = (card1_val == card2_val);
  assign wr_nxt   = wr_idx + LOC_W'(1);
  assign wr_val   = VAL_W'(wr_nxt >> 1) + VAL_W'(1);
  assign scores   = score_r;
  assign state    = state_q;

  reveal_timer #(.W(TMR_W)) u_timer (
    .clk       (Clk),
    .reset     (Reset),
    .start     (tmr_start),
    .load_value(TMR_W'(SHOW_CYCLES)),
    .done      (show_done)
  );

  // State register
  always_ff @(posedge Clk) begin
    if (Reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic plus the per-cycle accept/pick strobes
  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    pick      = 1'b0;
    tmr_start = 1'b0;
    case (state_q)
      ST_IDLE:    if (Start) state_d = ST_SHUFFLE;
      ST_SHUFFLE: begin
        accept = RandValid && ({1'b0, RandIn} < TWO_N_X) && !used[RandIn];
        if (accept && k == LAST_LOC) state_d = ST_WRITE;
      end
      ST_WRITE:   if (wr_idx == LAST_LOC) state_d = ST_S1C;
      ST_S1C: begin
        if (sel_rise && !removed[CardSelectLoc]) begin
          pick    = 1'b1;
          state_d = ST_F1C;
        end
      end
      ST_F1C:     if (!Select) state_d = ST_S2C;
      ST_S2C: begin
        if (sel_rise && !removed[CardSelectLoc] && CardSelectLoc != card1_loc) begin
          pick      = 1'b1;
          tmr_start = 1'b1;
          state_d   = ST_SHOW;
        end
      end
      ST_SHOW:     if (show_done) state_d = ST_RESOLVE1;
      ST_RESOLVE1: state_d = ST_RESOLVE2;
      ST_RESOLVE2: state_d = (numMatches == VAL_W'(NUM_PAIRS)) ? ST_WIN : ST_S1C;
      ST_WIN:      if (Ack) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // Highest score wins; strict compare keeps ties on the lowest index
  always_comb begin
    best    = '0;
    best_sc = score_r[0];
    for (int p = 1; p < NUM_PLAYERS; p++) begin
      if (score_r[p] > best_sc) begin
        best    = PL_W'(p);
        best_sc = score_r[p];
      end
    end
  end

  // Shuffle perm, board writes (registered, issued on the entering edge), scoring
  always_ff @(posedge Clk) begin
    if (Reset) begin
      WriteEnable <= 1'b0;
      dataLoc     <= '0;
      dataOut     <= '0;
      numMatches  <= '0;
      curPlayer   <= '0;
      score_r     <= '0;
      winner      <= '0;
      used        <= '0;
      removed     <= '0;
      k           <= '0;
      wr_idx      <= '0;
      sel_prev    <= 1'b0;
      card1_loc   <= '0;
      card1_val   <= '0;
      card2_loc   <= '0;
      card2_val   <= '0;
    end else begin
      WriteEnable <= 1'b0;
      sel_prev    <= Select;
      winner      <= best;
      case (state_q)
        ST_IDLE: begin
          k          <= '0;
          wr_idx     <= '0;
          used       <= '0;
          removed    <= '0;
          score_r    <= '0;
          numMatches <= '0;
          curPlayer  <= '0;
        end
        ST_SHUFFLE: begin
          if (accept) begin
            perm[k]      <= RandIn;
            used[RandIn] <= 1'b1;
            k            <= k + LOC_W'(1);
            // Last slot filled: first write goes out with the WRITE state
            if (k == LAST_LOC) begin
              WriteEnable <= 1'b1;
              dataLoc     <= perm[0];
              dataOut     <= {FACE_DOWN, VAL_W'(1)};
              wr_idx      <= '0;
            end
          end
        end
        ST_WRITE: begin
          if (wr_idx != LAST_LOC) begin
            WriteEnable <= 1'b1;
            dataLoc     <= perm[wr_nxt];
            dataOut     <= {FACE_DOWN, wr_val};
            wr_idx      <= wr_nxt;
          end
        end
        ST_S1C: begin
          if (pick) begin
            card1_loc   <= CardSelectLoc;
            card1_val   <= CardSelectData;
            WriteEnable <= 1'b1;
            dataLoc     <= CardSelectLoc;
            dataOut     <= {FACE_UP, CardSelectData};
          end
        end
        ST_S2C: begin
          if (pick) begin
            card2_loc   <= CardSelectLoc;
            card2_val   <= CardSelectData;
            WriteEnable <= 1'b1;
            dataLoc     <= CardSelectLoc;
            dataOut     <= {FACE_UP, CardSelectData};
          end
        end
        ST_SHOW: begin
          if (show_done) begin
            WriteEnable <= 1'b1;
            dataLoc     <= card1_loc;
            dataOut     <= {is_match ? REMOVED : FACE_DOWN, card1_val};
          end
        end
        ST_RESOLVE1: begin
          WriteEnable <= 1'b1;
          dataLoc     <= card2_loc;
          dataOut     <= {is_match ? REMOVED : FACE_DOWN, card2_val};
          if (is_match) begin
            removed[card1_loc] <= 1'b1;
            removed[card2_loc] <= 1'b1;
            numMatches         <= numMatches + VAL_W'(1);
            for (int p = 0; p < NUM_PLAYERS; p++)
              if (PL_W'(p) == curPlayer) score_r[p] <= score_r[p] + VAL_W'(1);
          end else begin
            curPlayer <= (curPlayer == PL_W'(NUM_PLAYERS - 1)) ? '0 : curPlayer + PL_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
